// File: rtl/run_ctrl_pkg.sv
// Shared types and defaults for the run sequencer that drives the core start/ack handshake.
package run_ctrl_pkg;

  localparam int unsigned CNT_W_DEFAULT   = 16;
  localparam int unsigned TIMEOUT_DEFAULT = 4096;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StRun   = 2'd2,
    StResp  = 2'd3
  } run_state_t;

endpackage

// File: rtl/run_cycle_counter.sv
// Up-counter with clear/enable; hit flags the cycle whose increment would reach limit.
module run_cycle_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             hit
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W:0]   count_inc;

  // One extra bit so count+1 cannot alias back to zero in the compare.
  assign count_inc = {1'b0, count_q} + {{CNT_W{1'b0}}, 1'b1};
  assign hit       = (count_inc == {1'b0, limit});
  assign count     = count_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_inc[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/run_controller.sv
// Run sequencer: pulses core_start, times the run until ack or timeout, and
// returns the cycle count over a valid/ready response channel.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned TIMEOUT      = TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W        = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  output logic             core_start,
  input  logic             core_ack,
  output logic             busy,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_timeout,
  output logic [CNT_W-1:0] rsp_cycles,
  output logic [7:0]       run_count
);

  run_state_t       state_q, state_d;
  logic [CNT_W-1:0] rsp_cycles_q, rsp_cycles_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  logic [7:0]       run_count_q, run_count_d;
  logic [CNT_W-1:0] run_cnt;
  logic             start_hit, run_hit;

  // Each counter is held clear outside its own state, so it always starts from 0.
  run_cycle_counter #(
    .CNT_W (CNT_W)
  ) u_start_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q != StStart),
    .enable (state_q == StStart),
    .limit  (CNT_W'(START_CYCLES)),
    .count  (),
    .hit    (start_hit)
  );

  run_cycle_counter #(
    .CNT_W (CNT_W)
  ) u_run_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q != StRun),
    .enable (state_q == StRun),
    .limit  (CNT_W'(TIMEOUT)),
    .count  (run_cnt),
    .hit    (run_hit)
  );

  always_comb begin
    state_d       = state_q;
    rsp_cycles_d  = rsp_cycles_q;
    rsp_timeout_d = rsp_timeout_q;
    run_count_d   = run_count_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) state_d = StStart;
      end
      StStart: begin
        if (start_hit) state_d = StRun;
      end
      StRun: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (core_ack) begin
          state_d       = StResp;
          rsp_cycles_d  = run_cnt + CNT_W'(1);
          rsp_timeout_d = 1'b0;
        end else if (run_hit) begin
          state_d       = StResp;
          rsp_cycles_d  = CNT_W'(TIMEOUT);
          rsp_timeout_d = 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          run_count_d = run_count_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      rsp_cycles_q  <= '0;
      rsp_timeout_q <= 1'b0;
      run_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      rsp_cycles_q  <= rsp_cycles_d;
      rsp_timeout_q <= rsp_timeout_d;
      run_count_q   <= run_count_d;
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign core_start  = (state_q == StStart);
  assign busy        = (state_q == StStart) || (state_q == StRun);
  assign rsp_valid   = (state_q == StResp);
  assign rsp_cycles  = rsp_cycles_q;
  assign rsp_timeout = rsp_timeout_q;
  assign run_count   = run_count_q;

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: instance 0 uses defaults, instance 1 uses TIMEOUT=8.
module tb_run_controller;

  localparam int unsigned S = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid   [2];
  logic        req_ready   [2];
  logic        core_start  [2];
  logic        core_ack    [2];
  logic        busy        [2];
  logic        rsp_valid   [2];
  logic        rsp_ready   [2];
  logic        rsp_timeout [2];
  logic [15:0] rsp_cycles  [2];
  logic [7:0]  run_count   [2];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    run_controller #(
      .TIMEOUT (g == 0 ? 4096 : 8)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid[g]),
      .req_ready   (req_ready[g]),
      .core_start  (core_start[g]),
      .core_ack    (core_ack[g]),
      .busy        (busy[g]),
      .rsp_valid   (rsp_valid[g]),
      .rsp_ready   (rsp_ready[g]),
      .rsp_timeout (rsp_timeout[g]),
      .rsp_cycles  (rsp_cycles[g]),
      .run_count   (run_count[g])
    );
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction; the expected timeline follows from the run rules:
  // S start cycles, then min(ack cycle, timeout) run cycles, then the response.
  task automatic do_run(input int d, input int ack_k, input int hold, input bit stray);
    int          t_lim;
    int          k_end;
    logic        exp_to;
    logic [15:0] exp_cyc;
    t_lim = (d == 0) ? 4096 : 8;
    if (ack_k > 0 && ack_k <= t_lim) begin
      k_end  = ack_k;
      exp_to = 1'b0;
    end else begin
      k_end  = t_lim;
      exp_to = 1'b1;
    end
    exp_cyc = 16'(k_end);
    n_checks++;
    if (req_ready[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_ready d=%0d got=%b exp=1", d, req_ready[d]);
    end
    req_valid[d] = 1'b1;
    step();
    req_valid[d] = 1'b0;
    for (int i = 1; i <= S; i++) begin
      n_checks++;
      if ({core_start[d], busy[d], req_ready[d], rsp_valid[d]} !== 4'b1100) begin
        n_fail++;
        $display("FAIL start_phase d=%0d cyc=%0d got=%b%b%b%b exp=1100", d, i,
                 core_start[d], busy[d], req_ready[d], rsp_valid[d]);
      end
      if (stray && i == 1) core_ack[d] = 1'b1;
      step();
      core_ack[d] = 1'b0;
    end
    for (int k = 1; k <= k_end; k++) begin
      n_checks++;
      if ({core_start[d], busy[d], req_ready[d], rsp_valid[d]} !== 4'b0100) begin
        n_fail++;
        $display("FAIL run_phase d=%0d k=%0d got=%b%b%b%b exp=0100", d, k,
                 core_start[d], busy[d], req_ready[d], rsp_valid[d]);
      end
      if (k == ack_k) core_ack[d] = 1'b1;
      step();
      core_ack[d] = 1'b0;
    end
    for (int h = 0; h <= hold; h++) begin
      n_checks++;
      if ({rsp_valid[d], req_ready[d], busy[d], rsp_timeout[d], rsp_cycles[d]} !==
          {3'b100, exp_to, exp_cyc}) begin
        n_fail++;
        $display("FAIL resp d=%0d h=%0d got v=%b rdy=%b busy=%b to=%b cyc=%0d exp v=1 rdy=0 busy=0 to=%b cyc=%0d",
                 d, h, rsp_valid[d], req_ready[d], busy[d], rsp_timeout[d], rsp_cycles[d],
                 exp_to, exp_cyc);
      end
      if (h < hold) begin
        req_valid[d] = 1'($urandom_range(0, 1));
        step();
      end
    end
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    step();
    rsp_ready[d] = 1'b0;
    exp_cnt[d] = (exp_cnt[d] + 1) % 256;
    n_checks++;
    if ({rsp_valid[d], req_ready[d], busy[d]} !== 3'b010 || run_count[d] !== 8'(exp_cnt[d])) begin
      n_fail++;
      $display("FAIL consume d=%0d got v=%b rdy=%b busy=%b cnt=%0d exp v=0 rdy=1 busy=0 cnt=%0d",
               d, rsp_valid[d], req_ready[d], busy[d], run_count[d], exp_cnt[d]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({req_ready[d], core_start[d], busy[d], rsp_valid[d], rsp_timeout[d]} !== 5'b10000 ||
          rsp_cycles[d] !== 16'd0 || run_count[d] !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_vals d=%0d got rdy=%b st=%b busy=%b v=%b to=%b cyc=%0d cnt=%0d exp 1 0 0 0 0 0 0",
                 d, req_ready[d], core_start[d], busy[d], rsp_valid[d], rsp_timeout[d],
                 rsp_cycles[d], run_count[d]);
      end
      exp_cnt[d] = 0;
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    do_run(0, 5, 0, 1'b0);
  endtask

  task automatic test_timeout();
    do_run(1, 0, 0, 1'b0);
    do_run(1, 9, 1, 1'b0);
  endtask

  task automatic test_ack_on_timeout();
    do_run(1, 8, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_run(0, 3, 10, 1'b1);
    do_run(1, 2, 10, 1'b1);
  endtask

  task automatic test_mid_reset();
    req_valid[0] = 1'b1;
    step();
    req_valid[0] = 1'b0;
    for (int i = 0; i < S + 2; i++) step();
    reset = 1'b1;
    step();
    n_checks++;
    if ({core_start[0], busy[0], req_ready[0], rsp_valid[0]} !== 4'b0010 || run_count[0] !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_in_run got st=%b busy=%b rdy=%b v=%b cnt=%0d exp 0 0 1 0 0",
               core_start[0], busy[0], req_ready[0], rsp_valid[0], run_count[0]);
    end
    reset = 1'b0;
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    step();
    req_valid[1] = 1'b1;
    step();
    req_valid[1] = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if ({core_start[1], busy[1], req_ready[1]} !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_in_start got st=%b busy=%b rdy=%b exp 0 0 1",
               core_start[1], busy[1], req_ready[1]);
    end
    do_run(0, 4, 1, 1'b0);
    do_run(1, 1, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      int d;
      int ack_k;
      d     = int'($urandom_range(0, 1));
      ack_k = (d == 0) ? int'($urandom_range(1, 12)) : int'($urandom_range(0, 11));
      do_run(d, ack_k, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    step();
    for (int n = 0; n < 256; n++) do_run(1, 1, 0, 1'b0);
    n_checks++;
    if (run_count[1] !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap got=%0d exp=0", run_count[1]);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      core_ack[d]  = 1'b0;
      rsp_ready[d] = 1'b0;
    end
    test_reset();
    test_basic();
    test_timeout();
    test_ack_on_timeout();
    test_backpressure();
    test_mid_reset();
    test_random();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
